// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// combinational instruction memory (slave).
interface instruction_fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input  imem_data);
  modport slave  (input  imem_addr, output imem_data);
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, IF/ID pipeline register and the opcode/function
// fields consumed by the controller, with redirect, flush and stall control.
module instruction_fetch_stage #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'hF000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       killF,
  input  logic [1:0]                 PCSrc,
  input  logic [PC_W-1:0]            jump_target,
  input  logic [PC_W-1:0]            branch_target,
  input  logic [PC_W-1:0]            return_addr,
  instruction_fetch_stage_if.master  imem,
  output logic [INSTR_W-1:0]         ifid_instr,
  output logic [PC_W-1:0]            ifid_pc_plus1,
  output logic                       ifid_valid,
  output logic [3:0]                 opcode,
  output logic [2:0]                 functionCode,
  output logic [31:0]                fetch_count
);

  logic [PC_W-1:0]    pc_q, pc_d, pc_plus1;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_plus1_q, pc_plus1_d;
  logic               valid_q, valid_d;
  logic [31:0]        count_q, count_d;
  logic               load_real;

  // Natural PC_W-bit arithmetic gives the required wrap at 2^PC_W-1.
  assign pc_plus1  = pc_q + 1'b1;
  assign load_real = !killF && !stall;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (PCSrc != 2'b00) begin
      unique case (PCSrc)
        2'b01:   pc_d = jump_target;
        2'b10:   pc_d = branch_target;
        default: pc_d = return_addr;
      endcase
    end else if (!stall) begin
      pc_d = pc_plus1;
    end
  end

  // Kill wins over stall, so a flushed slot never holds stale content.
  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (killF) begin
      instr_d    = NOP_INSTR;
      pc_plus1_d = '0;
      valid_d    = 1'b0;
    end else if (load_real) begin
      instr_d    = imem.imem_data;
      pc_plus1_d = pc_plus1;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign ifid_instr     = instr_q;
  assign ifid_pc_plus1  = pc_plus1_q;
  assign ifid_valid     = valid_q;
  assign opcode         = instr_q[15:12];
  assign functionCode   = instr_q[2:0];
  assign fetch_count    = count_q;

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage for the 16-bit pipelined processor. It owns the PC and the IF/ID pipeline register, and produces the `opcode` / `functionCode` fields the controller decodes. It also applies the controller's `PCSrc`, `killF` and `stall` back onto the fetch path. The block sits between instruction memory and the controller/decode stage, and forms the producing end of the controller's instruction-field interface.

## Interface
- `PC_W`, 16, PC and address width (word-addressed)
- `INSTR_W`, 16, instruction width; opcode is `[15:12]`, function code is `[2:0]`
- `RESET_PC`, 0, PC value loaded on reset
- `NOP_INSTR`, 16'hF000, bubble instruction (opcode 1111)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `stall`  in  1  hold PC and IF/ID (load-use hazard)
- `killF`  in  1  flush IF/ID to bubble (taken branch/jump/RET)
- `PCSrc`  in  2  next-PC select: 00 PC+1, 01 `jump_target`, 10 `branch_target`, 11 `return_addr`
- `jump_target`  in  PC_W  J-type target (JMP/CALL)
- `branch_target`  in  PC_W  BEQ/BNE/FOR target
- `return_addr`  in  PC_W  RET target (RR contents)
- `imem_addr`  out  PC_W  instruction memory address, equals PC
- `imem_data`  in  INSTR_W  instruction memory read data, combinational from `imem_addr`
- `ifid_instr`  out  INSTR_W  registered instruction
- `ifid_pc_plus1`  out  PC_W  registered PC+1 of that instruction (CALL return value)
- `ifid_valid`  out  1  1 = real instruction, 0 = bubble
- `opcode`  out  4  `ifid_instr[15:12]`
- `functionCode`  out  3  `ifid_instr[2:0]`
- `fetch_count`  out  32  number of real instructions latched into IF/ID

## Operation
- **PC register, priority order:**
  - `reset`: PC ← `RESET_PC`.
  - `PCSrc` ≠ 00: PC ← selected target. A redirect overrides `stall`.
  - `stall`: PC holds.
  - Otherwise: PC ← PC+1, computed modulo 2^PC_W.
- **IF/ID register, priority order:**
  - `reset`: `ifid_instr` ← `NOP_INSTR`, `ifid_pc_plus1` ← 0, `ifid_valid` ← 0.
  - `killF`: `ifid_instr` ← `NOP_INSTR`, `ifid_valid` ← 0, `ifid_pc_plus1` ← 0. `killF` overrides `stall`.
  - `stall`: hold all fields.
  - Otherwise: `ifid_instr` ← `imem_data`, `ifid_pc_plus1` ← PC+1, `ifid_valid` ← 1.
- **fetch_count:**
  - Reset value 0.
  - Increments by 1 on each edge where IF/ID loads a real instruction (not reset, not kill, not stall).
  - Wraps from 2^32−1 to 0.
- `opcode` and `functionCode` are pure slices of `ifid_instr`. No further decoding is done here.
- **PCSrc = 11 (RET) with `return_addr` = PC:** the same address is refetched. This is legal and needs no special case.

## Timing
- **Reset values:**
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC`.
  - `ifid_instr` = `NOP_INSTR`, so `opcode` = 4'b1111 and `functionCode` = 3'b000.
  - `ifid_pc_plus1` = 0, `ifid_valid` = 0, `fetch_count` = 0.
- **Latency:** the instruction at address A appears on `ifid_instr` one edge after PC = A.
- **Redirect at edge N** (`PCSrc` ≠ 00, `killF` = 1):
  - After edge N: PC = target and IF/ID = bubble.
  - After edge N+1: the target instruction is in IF/ID.
  - Exactly one bubble is produced per redirect.
- **Stall held for k cycles:** PC and IF/ID are unchanged for k edges and resume on the first edge with `stall` = 0. `fetch_count` does not advance during a stall.
- **Simultaneous events:**
  - `stall` + `killF` with `PCSrc` = 00: PC holds and IF/ID flushes.
  - `stall` + `PCSrc` ≠ 00: PC redirects and IF/ID follows the `killF` / `stall` rule.
- **Reset mid-stream:** takes effect on the next edge regardless of `stall`, `killF` or `PCSrc`. The in-flight IF/ID content is discarded.
- **PC wrap:** PC = 2^PC_W−1 with no redirect goes to 0. `ifid_pc_plus1` wraps the same way.

## Test plan
- **Reset and free run:** reset 1 cycle, memory holds AND/ADD/SUB (16'h0000, 16'h0001, 16'h0002) at addresses 0..2 → after edges 1..3, `opcode` = 0000 and `functionCode` = 000, 001, 010. `ifid_pc_plus1` = 1, 2, 3; `ifid_valid` = 1; `fetch_count` = 3.
- **JMP redirect:** at PC = 5, drive `PCSrc` = 01, `jump_target` = 16'h0040, `killF` = 1 for one cycle → next cycle `ifid_valid` = 0 and `opcode` = 1111, PC = 0x40. One edge later, IF/ID holds mem[0x40] and `ifid_pc_plus1` = 0x41.
- **Stall:** `stall` = 1 for 3 cycles at PC = 8 → PC stays 8, IF/ID holds the instruction from address 7, `fetch_count` is frozen. IF/ID loads address 8 on the first cycle after `stall` drops.
- **Stall + kill + BEQ redirect in the same cycle:** `stall` = 1, `killF` = 1, `PCSrc` = 10, `branch_target` = 16'h0010 → PC = 0x10 and IF/ID = bubble.
- **CALL/RET round trip:** CALL at address 3 captures `ifid_pc_plus1` = 4. A later `PCSrc` = 11 with `return_addr` = 4 makes the instruction at address 4 appear in IF/ID two edges later.
- **Wrap and reset mid-stream:**
  - PC = 16'hFFFF, free run → next PC = 0 and `ifid_pc_plus1` = 0.
  - Then assert `reset` during an active stall → all outputs return to their reset values on the next edge.
